multdiv_iter_unit: RTL and testbench

Iterative signed multiply/divide responder for the processor's multdiv port. Accepts a one-cycle `ctrl_Mult` or `ctrl_Div` pulse with operands, computes over a fixed number of cycles, then pulses `data_resultRDY` with the result and exception flag. It is the execution end of the operand/ready handshake that the CP-3 bench and pipeline stall logic drive. Radix-4 Booth multiply and non-restoring divide share one datapath register set.

---
 rtl/multdiv_pkg.sv | 27 ++
 rtl/multdiv_booth4_recode.sv | 17 +
 rtl/multdiv_iter_unit.sv | 180 ++++++++++++++++++
 tb/tb_multdiv_iter_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and latency helpers for the iterative multiply/divide unit.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_MULT = 2'd1,
        OP_DIV  = 2'd2
    } md_op_t;

    // Radix-4 Booth retires two multiplier bits per iteration
    function automatic int unsigned MULT_ITERS(input int unsigned width);
        return width / 2;
    endfunction

    // Non-restoring divide produces one quotient bit per iteration
    function automatic int unsigned DIV_ITERS(input int unsigned width);
        return width;
    endfunction

endpackage

// File: rtl/multdiv_booth4_recode.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window {b(i+1), b(i), b(i-1)}
// to a partial-product select of 0, +-1 or +-2 times the multiplicand.
module booth4_recode (
    input  logic [2:0] i_window,
    output logic       o_neg,
    output logic       o_one,
    output logic       o_two
);

    // Decode the window into magnitude (one/two) and sign
    always_comb begin
        o_one = i_window[1] ^ i_window[0];
        o_two = (i_window == 3'b011) || (i_window == 3'b100);
        o_neg = i_window[2] && (i_window != 3'b111);
    end

endmodule

// File: rtl/multdiv_iter_unit.sv
// Iterative signed multiply (radix-4 Booth) / divide (non-restoring) unit.
// Optional feature: define MULTDIV_EARLY_OUT_EN to complete divide-by-zero and
// multiply-by-zero one edge after the start pulse.
module multdiv_iter_unit
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_Mult,
    input  logic             ctrl_Div,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int unsigned     CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   MULT_CNT = CW'(MULT_ITERS(WIDTH));
    localparam logic [CW-1:0]   DIV_CNT  = CW'(DIV_ITERS(WIDTH));
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_t        r_state, w_next;
    md_op_t           w_op;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_mcand;   // multiplicand, or divisor magnitude
    logic [WIDTH-1:0] r_mq;      // multiplier/low product, or dividend/quotient
    logic [WIDTH+1:0] r_acc;     // high product accumulator, or partial remainder
    logic             r_q1;      // Booth extra bit below r_mq[0]
    logic             r_neg;     // quotient needs negation
    logic             r_dz;      // divisor was zero
    logic             r_dexc;    // divide exception (zero divisor or MIN/-1)
    logic [WIDTH-1:0] r_result;
    logic             r_exc;

    logic             w_last;
    logic             w_bneg, w_bone, w_btwo;
    logic [WIDTH+1:0] w_mc_ext, w_pp_mag, w_pp, w_msum;
    logic [WIDTH+1:0] w_rsh, w_dvs, w_dsum;
    logic [WIDTH-1:0] w_abs_a, w_abs_b;
    logic [WIDTH:0]   w_hi;
    logic             w_ovf;
    logic             w_mult_early, w_div_early;

    assign w_last = (r_cnt == '0);

    booth4_recode u_recode (
        .i_window ({r_mq[1:0], r_q1}),
        .o_neg    (w_bneg),
        .o_one    (w_bone),
        .o_two    (w_btwo)
    );

    // Start-pulse priority: multiply beats divide
    always_comb begin
        w_op = OP_NONE;
        if (ctrl_Mult)     w_op = OP_MULT;
        else if (ctrl_Div) w_op = OP_DIV;
    end

    // Datapath arithmetic for one iteration of either operation
    always_comb begin
        w_mc_ext = {{2{r_mcand[WIDTH-1]}}, r_mcand};
        w_pp_mag = '0;
        if (w_btwo)      w_pp_mag = {w_mc_ext[WIDTH:0], 1'b0};
        else if (w_bone) w_pp_mag = w_mc_ext;
        w_pp   = w_bneg ? (~w_pp_mag + 1'b1) : w_pp_mag;
        w_msum = r_acc + w_pp;

        w_rsh  = {r_acc[WIDTH:0], r_mq[WIDTH-1]};
        w_dvs  = {2'b00, r_mcand};
        w_dsum = r_acc[WIDTH+1] ? (w_rsh + w_dvs) : (w_rsh - w_dvs);

        w_abs_a = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
        w_abs_b = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

        w_hi  = {r_acc[WIDTH-1:0], r_mq[WIDTH-1]};
        w_ovf = !((&w_hi) || !(|w_hi));
    end

    // Zero-operand shortcut detection
`ifdef MULTDIV_EARLY_OUT_EN
    always_comb begin
        w_mult_early = (data_operandA == '0) || (data_operandB == '0);
        w_div_early  = (data_operandB == '0);
    end
`else
    always_comb begin
        w_mult_early = 1'b0;
        w_div_early  = 1'b0;
    end
`endif

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // FSM next state: any start pulse (re)launches an operation
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = IDLE;
            MULT, DIV: if (w_last) w_next = DONE;
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
        if (w_op == OP_MULT)     w_next = MULT;
        else if (w_op == OP_DIV) w_next = DIV;
    end

    // FSM outputs
    always_comb begin
        data_resultRDY = (r_state == DONE);
        busy           = (r_state == MULT) || (r_state == DIV);
        data_result    = r_result;
        data_exception = r_exc;
    end

    // Operand latch, iteration and completion writeback.
    // The counter-zero edge is a dedicated writeback step, so an early-out
    // start simply loads a zero count (and a zero product for multiply).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mq     <= '0;
            r_acc    <= '0;
            r_q1     <= 1'b0;
            r_neg    <= 1'b0;
            r_dz     <= 1'b0;
            r_dexc   <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else if (w_op == OP_MULT) begin
            r_mcand <= data_operandA;
            r_acc   <= '0;
            r_q1    <= 1'b0;
            r_neg   <= 1'b0;
            r_dz    <= 1'b0;
            r_dexc  <= 1'b0;
            r_mq    <= w_mult_early ? '0 : data_operandB;
            r_cnt   <= w_mult_early ? '0 : MULT_CNT;
        end else if (w_op == OP_DIV) begin
            r_mcand <= w_abs_b;
            r_mq    <= w_abs_a;
            r_acc   <= '0;
            r_q1    <= 1'b0;
            r_neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_dz    <= (data_operandB == '0);
            r_dexc  <= (data_operandB == '0) ||
                       ((data_operandA == MIN_INT) && (data_operandB == '1));
            r_cnt   <= w_div_early ? '0 : DIV_CNT;
        end else if (r_state == MULT) begin
            if (!w_last) begin
                r_acc <= {{2{w_msum[WIDTH+1]}}, w_msum[WIDTH+1:2]};
                r_mq  <= {w_msum[1:0], r_mq[WIDTH-1:2]};
                r_q1  <= r_mq[1];
                r_cnt <= r_cnt - CW'(1);
            end else begin
                r_result <= r_mq;
                r_exc    <= w_ovf;
            end
        end else if (r_state == DIV) begin
            if (!w_last) begin
                r_acc <= w_dsum;
                r_mq  <= {r_mq[WIDTH-2:0], !w_dsum[WIDTH+1]};
                r_cnt <= r_cnt - CW'(1);
            end else begin
                r_result <= r_dz ? '0 : (r_neg ? (~r_mq + 1'b1) : r_mq);
                r_exc    <= r_dexc;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_iter_unit.sv
// Self-checking bench for multdiv_iter_unit (WIDTH = 32) against an
// arithmetic reference model. Honours MULTDIV_EARLY_OUT_EN when defined.
module tb_multdiv_iter_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] data_operandA, data_operandB;
    logic        ctrl_Mult, ctrl_Div;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MULTDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    multdiv_iter_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_Mult      (ctrl_Mult),
        .ctrl_Div       (ctrl_Div),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed arithmetic plus the documented special cases
    task automatic model(input bit m, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic e, output int lat);
        longint p;
        int     sa, sb, q;
        sa = a;
        sb = b;
        if (m) begin
            p   = longint'(sa) * longint'(sb);
            r   = p[31:0];
            e   = (p != longint'(int'(p)));
            lat = (EARLY && (sa == 0 || sb == 0)) ? 1 : 17;
        end else begin
            lat = (EARLY && sb == 0) ? 1 : 33;
            if (sb == 0) begin
                r = '0; e = 1'b1;
            end else if (sa == 32'sh8000_0000 && sb == -1) begin
                r = 32'h8000_0000; e = 1'b1;
            end else begin
                q = sa / sb;
                r = q; e = 1'b0;
            end
        end
    endtask

    task automatic pulse(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_Mult = m; ctrl_Div = d;
        data_operandA = a; data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_Mult = 1'b0; ctrl_Div = 1'b0;
        data_operandA = $urandom; data_operandB = $urandom;
    endtask

    // Counts edges after the start edge until RDY, bounded at 100
    task automatic wait_rdy(output int n, output logic busy1);
        n = 0;
        busy1 = 1'b0;
        do begin
            @(posedge clock);
            #1;
            n++;
            if (n == 1) busy1 = busy;
        end while (!data_resultRDY && n < 100);
    endtask

    task automatic run_op(input string tag, input bit m, input bit d,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic        ee, b1;
        int          el, n;
        model(m, a, b, er, ee, el);
        pulse(m, d, a, b);
        wait_rdy(n, b1);
        check({tag, "_lat"}, n, el);
        check({tag, "_res"}, data_result, er);
        check({tag, "_exc"}, data_exception, ee);
        check({tag, "_busy_at_rdy"}, busy, 0);
        if (el > 1) check({tag, "_busy_k1"}, b1, 1);
        @(posedge clock);
        #1;
        check({tag, "_rdy_single"}, data_resultRDY, 0);
        check({tag, "_res_hold"}, data_result, er);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 4))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 40)) - 32'd20;
            2:       return '0;
            3:       return ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
            default: return 32'($urandom_range(0, 70000));
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n, cnt, at;
        logic        b1;
        logic [31:0] res;
        bit          m;

        reset_n = 1'b0;
        ctrl_Mult = 1'b0; ctrl_Div = 1'b0;
        data_operandA = '0; data_operandB = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_result", data_result, 0);
        check("rst_exc", data_exception, 0);
        check("rst_rdy", data_resultRDY, 0);
        check("rst_busy", busy, 0);
        @(negedge clock);
        reset_n = 1'b1;

        run_op("mul_7x-6", 1, 0, 32'd7, -32'sd6);
        run_op("mul_65536sq", 1, 0, 32'd65536, 32'd65536);
        run_op("mul_46341sq", 1, 0, 32'd46341, 32'd46341);
        run_op("mul_min_min", 1, 0, 32'h8000_0000, 32'h8000_0000);
        run_op("div_-7/2", 0, 1, -32'sd7, 32'd2);
        run_op("div_5/0", 0, 1, 32'd5, 32'd0);
        run_op("div_min/-1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_9/0", 0, 1, 32'd9, 32'd0);
        run_op("mul_0x123", 1, 0, 32'd0, 32'd123);
        run_op("both_5x6", 1, 1, 32'd5, 32'd6);

        // Abort: divide started at k, multiply at k+10 -> single RDY at k+27
        pulse(0, 1, 32'd100, 32'd7);
        repeat (9) begin @(posedge clock); #1; end
        pulse(1, 0, 32'd3, 32'd4);
        cnt = 0; at = 0; res = '0;
        for (int e = 11; e <= 50; e++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                cnt++;
                at = e;
                if (cnt == 1) res = data_result;
            end
        end
        check("abort_rdy_count", cnt, 1);
        check("abort_rdy_edge", at, 27);
        check("abort_res", res, 12);

        // Reset mid-divide clears outputs at once and suppresses RDY
        run_op("pre_rst_mul", 1, 0, 32'd7, -32'sd6);
        pulse(0, 1, 32'd1000, 32'd3);
        repeat (4) begin @(posedge clock); #1; end
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_result", data_result, 0);
        check("midrst_exc", data_exception, 0);
        check("midrst_rdy", data_resultRDY, 0);
        check("midrst_busy", busy, 0);
        @(negedge clock);
        reset_n = 1'b1;
        cnt = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) cnt++;
        end
        check("midrst_no_rdy", cnt, 0);
        run_op("post_rst_2x3", 1, 0, 32'd2, 32'd3);

        // Pulse in the DONE cycle: old RDY delivered, new op starts that edge
        pulse(1, 0, 32'd7, 32'd8);
        wait_rdy(n, b1);
        check("done_first_lat", n, 17);
        check("done_first_res", data_result, 56);
        pulse(0, 1, 32'd50, 32'd5);
        wait_rdy(n, b1);
        check("done_second_lat", n, 33);
        check("done_second_res", data_result, 10);
        @(posedge clock);
        #1;

        for (int i = 0; i < 30; i++) begin
            m = ($urandom_range(0, 1) != 0);
            run_op(m ? "rand_mul" : "rand_div", m, !m, rnd_operand(), rnd_operand());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
